robm_keyed_param: RTL and testbench
===================================

Name: robm_keyed_param

Overview:
- Parametrised successor of the keyed robm controller benchmark, used as a locked-FSM / trigger benchmark.
- Implements the 7-state robm control FSM with up to 4 key-locked transitions. Each locked transition goes to either a genuine state or a decoy twin state.
- Decoy twins behave like the genuine state until a saturating visit counter reaches a parametrised threshold. After that they mask or flip outputs.
- Sits standalone in the benchmark set. Inputs come from the bench; outputs are compared against the unlocked golden model.

Parameters:
- KEY_W, 4, number of active lock points (1..4); lock points with index >= KEY_W are unlocked (always genuine).
- KEY_VAL, 4'b1010, correct key; bit i selects the genuine branch at lock point i.
- CNT_W, 4, visit counter width.
- TRIG_TH, 5, decoy visit number at which the payload activates (1..2^CNT_W-1).
- MODE, 0, payload type: 0 = force the decoy state's outputs to 0; 1 = XOR the state's outputs with FLIP_MASK.
- FLIP_MASK, 10'h3FF, XOR mask used when MODE=1.

Ports:
- clk  input  1  clock; state and counter update on the falling edge.
- rst  input  1  asynchronous active-low reset.
- x  input  12  condition inputs; x[0]=x1 … x[11]=x12.
- key  input  KEY_W  key inputs.
- y  output  10  Mealy control outputs; y[0]=y1 … y[9]=y10.
- fired  output  1  registered-derived flag: 1 when cnt >= TRIG_TH.

Behaviour:
- Reset (rst=0, async): state=S1, cnt=0. While rst=0, y=0 and fired=0.
- Timing: y is combinational from state and inputs (same-cycle Mealy). State and cnt update on the negedge of clk.
- States: S1..S7, plus decoys S2D, S6D, S7D. Any unused encoding gives y=0 and next state S1.
- Notation: gj(i) means key[i]==KEY_VAL[i], or i >= KEY_W.
- S1, priority order:
  - x1&x11&x12: y4; goes to S2 if gj(1), else S2D.
  - x1&x11&~x12: y7,y8; goes to S3.
  - x1&~x11&x12&x8: y1,y2; goes to S4.
  - …~x8&x5: y2,y3; goes to S4.
  - …~x8&~x5&x6: y10; goes to S5.
  - …~x8&~x5&~x6: y4; goes to S2.
  - x1&~x11&~x12&x10&x9: y10; goes to S5.
  - …x10&~x9: y1,y2; goes to S4.
  - …~x10&x9: y2,y3; goes to S4.
  - …~x10&~x9: y4; goes to S2.
  - ~x1: no outputs; stays in S1.
- S2: y5; goes to S1.
- S3: y6; goes to S6 if gj(0), else S6D.
- S4:
  - x4: y4; goes to S2 if gj(3), else S2D.
  - ~x4: stays in S4.
- S5:
  - x12: y2,y9; goes to S7 if gj(2), else S7D.
  - ~x12: y2,y3; goes to S4.
- S6:
  - x2&x3: y1,y2; goes to S4.
  - x2&~x3: y2,y3; goes to S4.
  - ~x2: y4; goes to S2.
- S7:
  - x7: y2,y3; goes to S4.
  - ~x7: stays in S7.
- Decoy outputs and successors: S2D, S6D and S7D produce the same nominal outputs and successors as their twins.
- Decoy visit counting: every clock edge taken while in a decoy state increments cnt, saturating at 2^CNT_W-1.
- Payload: active in a decoy state when cnt+1 >= TRIG_TH, computed in CNT_W+1 bits.
  - MODE=0: y=0.
  - MODE=1: y = nominal y XOR FLIP_MASK.
  - Payload never affects next-state.
- With TRIG_TH=5: decoy visits 1–4 are clean; visit 5 onward is corrupted.
- cnt is cleared only by rst. A correct key never changes cnt.
- A decoy state held across several edges (S7D with ~x7) counts once per edge.
- Key changes mid-run take effect at the next lock decision only. The current state is unaffected.
- Reset asserted mid-run immediately forces S1, cnt=0, y=0. This applies even inside a decoy state with the payload active.

Test Plan:
- Correct key 4'b1010, walk S1 (x1,x11,~x12) → S3 → S6 (x2,x3) → S4 → S2 (x4) → S1 → y sequence 0C0h, 020h, 003h, 008h, 010h; cnt stays 0 and fired=0 throughout.
- key[0] wrong, MODE=0, TRIG_TH=5, loop S1→S3→S6D five times with x2&x3 → S6D y=003h on visits 1–4, y=000h on visit 5; fired=1 after the fifth edge.
- MODE=1, FLIP_MASK=10'h3FF, TRIG_TH=1, key[2] wrong, S5 with x12 → first S7D cycle has y=3F9h (006h XOR 3FFh); next state S7D with ~x7, S4 with x7.
- KEY_W=2 with key[3] input ignored, S4 with x4 → always goes to S2, never S2D; cnt=0.
- CNT_W=2, TRIG_TH=3, more than 5 decoy visits → cnt saturates at 3 with no wrap; payload stays active.
- rst pulse low while in S6D with payload active → y=0 immediately; after release, state=S1, cnt=0, fired=0.

Source files
------------

// File: rtl/robm_keyed_param.sv
// robm_keyed_param: 7-state robm control FSM with up to four key-locked
// transitions. A wrong key bit at a lock point diverts the machine into a
// decoy twin (S2D/S6D/S7D) that mirrors its genuine twin until a saturating
// visit counter reaches TRIG_TH, after which the decoy's outputs are either
// forced to zero (MODE=0) or XORed with FLIP_MASK (MODE=1).
// State and counter advance on the falling edge of clk; y is Mealy.
module robm_keyed_param #(
  parameter int         KEY_W     = 4,
  parameter logic [3:0] KEY_VAL   = 4'b1010,
  parameter int         CNT_W     = 4,
  parameter int         TRIG_TH   = 5,
  parameter int         MODE      = 0,
  parameter logic [9:0] FLIP_MASK = 10'h3FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      x,
  input  logic [KEY_W-1:0] key,
  output logic [9:0]       y,
  output logic             fired
);

  typedef enum logic [3:0] {
    S1  = 4'd0,
    S2  = 4'd1,
    S3  = 4'd2,
    S4  = 4'd3,
    S5  = 4'd4,
    S6  = 4'd5,
    S7  = 4'd6,
    S2D = 4'd7,
    S6D = 4'd8,
    S7D = 4'd9
  } state_t;

  // One-hot output codes, y1 is bit 0.
  localparam logic [9:0] Y1  = 10'h001;
  localparam logic [9:0] Y2  = 10'h002;
  localparam logic [9:0] Y3  = 10'h004;
  localparam logic [9:0] Y4  = 10'h008;
  localparam logic [9:0] Y5  = 10'h010;
  localparam logic [9:0] Y6  = 10'h020;
  localparam logic [9:0] Y7  = 10'h040;
  localparam logic [9:0] Y8  = 10'h080;
  localparam logic [9:0] Y9  = 10'h100;
  localparam logic [9:0] Y10 = 10'h200;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TH      = (CNT_W+1)'(TRIG_TH);
  localparam logic [CNT_W:0]   ONE_W   = (CNT_W+1)'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gj;
  logic [9:0]       y_nom;
  logic             in_decoy;
  logic             payload;

  // Named condition inputs, x1 is bit 0.
  logic x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12;
  assign x1  = x[0];
  assign x2  = x[1];
  assign x3  = x[2];
  assign x4  = x[3];
  assign x5  = x[4];
  assign x6  = x[5];
  assign x7  = x[6];
  assign x8  = x[7];
  assign x9  = x[8];
  assign x10 = x[9];
  assign x11 = x[10];
  assign x12 = x[11];

  // Genuine-branch select per lock point; unused lock points are always genuine.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lock
    if (gi < KEY_W) begin : g_active
      assign gj[gi] = (key[gi] == KEY_VAL[gi]);
    end else begin : g_open
      assign gj[gi] = 1'b1;
    end
  end

  // State register, falling-edge with asynchronous active-low reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and nominal Mealy outputs; decoys share their twin's behaviour.
  always_comb begin
    state_d = S1;
    y_nom   = '0;
    case (state_q)
      S1: begin
        if (!x1) begin
          state_d = S1;
        end else if (x11 && x12) begin
          y_nom   = Y4;
          state_d = gj[1] ? S2 : S2D;
        end else if (x11) begin
          y_nom   = Y7 | Y8;
          state_d = S3;
        end else if (x12) begin
          if (x8) begin
            y_nom   = Y1 | Y2;
            state_d = S4;
          end else if (x5) begin
            y_nom   = Y2 | Y3;
            state_d = S4;
          end else if (x6) begin
            y_nom   = Y10;
            state_d = S5;
          end else begin
            y_nom   = Y4;
            state_d = S2;
          end
        end else begin
          if (x10 && x9) begin
            y_nom   = Y10;
            state_d = S5;
          end else if (x10) begin
            y_nom   = Y1 | Y2;
            state_d = S4;
          end else if (x9) begin
            y_nom   = Y2 | Y3;
            state_d = S4;
          end else begin
            y_nom   = Y4;
            state_d = S2;
          end
        end
      end
      S2, S2D: begin
        y_nom   = Y5;
        state_d = S1;
      end
      S3: begin
        y_nom   = Y6;
        state_d = gj[0] ? S6 : S6D;
      end
      S4: begin
        if (x4) begin
          y_nom   = Y4;
          state_d = gj[3] ? S2 : S2D;
        end else begin
          state_d = S4;
        end
      end
      S5: begin
        if (x12) begin
          y_nom   = Y2 | Y9;
          state_d = gj[2] ? S7 : S7D;
        end else begin
          y_nom   = Y2 | Y3;
          state_d = S4;
        end
      end
      S6, S6D: begin
        if (x2 && x3) begin
          y_nom   = Y1 | Y2;
          state_d = S4;
        end else if (x2) begin
          y_nom   = Y2 | Y3;
          state_d = S4;
        end else begin
          y_nom   = Y4;
          state_d = S2;
        end
      end
      S7: begin
        if (x7) begin
          y_nom   = Y2 | Y3;
          state_d = S4;
        end else begin
          state_d = S7;
        end
      end
      S7D: begin
        // The decoy twin holds in itself, so repeated edges keep counting.
        if (x7) begin
          y_nom   = Y2 | Y3;
          state_d = S4;
        end else begin
          state_d = S7D;
        end
      end
      default: begin
        y_nom   = '0;
        state_d = S1;
      end
    endcase
  end

  assign in_decoy = (state_q == S2D) || (state_q == S6D) || (state_q == S7D);

  // Saturating visit counter: one step per edge spent in any decoy state.
  always_comb begin
    cnt_d = cnt_q;
    if (in_decoy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Visit counter register, cleared only by reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current decoy visit is number cnt+1; widened so saturation cannot wrap.
  assign payload = in_decoy && (({1'b0, cnt_q} + ONE_W) >= TH);

  // Output stage: payload corrupts only y, never the next-state decision.
  always_comb begin
    y = y_nom;
    if (!rst) begin
      y = '0;
    end else if (payload) begin
      if (MODE == 0) begin
        y = '0;
      end else begin
        y = y_nom ^ FLIP_MASK;
      end
    end
  end

  assign fired = rst && ({1'b0, cnt_q} >= TH);

endmodule

// File: tb/tb_robm_keyed_param.sv
// Self-checking bench: four differently parameterised instances share clk,
// rst and x, and are compared every step against a rule-table reference model.
module tb_robm_keyed_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] x   = '0;
  logic [3:0]  k   = '0;
  logic [9:0]  y_dut [4];
  logic [3:0]  f_dut;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // dut0 defaults; dut1 MODE=1 TRIG_TH=1; dut2 KEY_W=2; dut3 CNT_W=2 TRIG_TH=3
  robm_keyed_param u0 (.clk(clk), .rst(rst), .x(x), .key(k), .y(y_dut[0]), .fired(f_dut[0]));
  robm_keyed_param #(.MODE(1), .TRIG_TH(1), .FLIP_MASK(10'h3FF)) u1 (
    .clk(clk), .rst(rst), .x(x), .key(k), .y(y_dut[1]), .fired(f_dut[1]));
  robm_keyed_param #(.KEY_W(2)) u2 (
    .clk(clk), .rst(rst), .x(x), .key(k[1:0]), .y(y_dut[2]), .fired(f_dut[2]));
  robm_keyed_param #(.CNT_W(2), .TRIG_TH(3)) u3 (
    .clk(clk), .rst(rst), .x(x), .key(k), .y(y_dut[3]), .fired(f_dut[3]));

  localparam logic [11:0] X1 = 12'h001, X2 = 12'h002, X3 = 12'h004, X4 = 12'h008;
  localparam logic [11:0] X5 = 12'h010, X6 = 12'h020, X7 = 12'h040, X8 = 12'h080;
  localparam logic [11:0] X9 = 12'h100, X10 = 12'h200, X11 = 12'h400, X12 = 12'h800;
  localparam logic [9:0]  Y1 = 10'h001, Y2 = 10'h002, Y3 = 10'h004, Y4 = 10'h008;
  localparam logic [9:0]  Y5 = 10'h010, Y6 = 10'h020, Y7 = 10'h040, Y8 = 10'h080;
  localparam logic [9:0]  Y9 = 10'h100, Y10 = 10'h200;

  typedef struct {
    int          st;
    logic [11:0] care;
    logic [11:0] val;
    logic [9:0]  yv;
    int          nx;
    int          lock;
  } rule_t;

  rule_t rules[$];

  // Per-instance configuration and model state (state 1..7 plus decoy flag).
  int   cfg_kw   [4] = '{4, 4, 2, 4};
  int   cfg_th   [4] = '{5, 1, 5, 3};
  int   cfg_cmax [4] = '{15, 15, 15, 3};
  int   cfg_mode [4] = '{0, 1, 0, 0};
  logic [3:0] kval   = 4'b1010;
  int   m_st  [4];
  bit   m_dec [4];
  int   m_cnt [4];
  logic [9:0] ys [4];
  logic [3:0] fs;

  task automatic add(input int st, input logic [11:0] on, input logic [11:0] off,
                     input logic [9:0] yv, input int nx, input int lock);
    rule_t r;
    r.st = st; r.care = on | off; r.val = on; r.yv = yv; r.nx = nx; r.lock = lock;
    rules.push_back(r);
  endtask

  function automatic int find_rule(input int st, input logic [11:0] xv);
    for (int i = 0; i < rules.size(); i++) begin
      if (rules[i].st == st && (xv & rules[i].care) == rules[i].val) return i;
    end
    return -1;
  endfunction

  function automatic logic [9:0] model_y(input int d, input logic [11:0] xv);
    int ri;
    logic [9:0] yn;
    ri = find_rule(m_st[d], xv);
    if (ri < 0) return 10'h000;
    yn = rules[ri].yv;
    if (m_dec[d] && (m_cnt[d] + 1 >= cfg_th[d])) yn = (cfg_mode[d] == 0) ? 10'h000 : (yn ^ 10'h3FF);
    return yn;
  endfunction

  task automatic model_adv(input int d, input logic [11:0] xv, input logic [3:0] kv);
    int ri;
    bit good;
    bit ndec;
    ri = find_rule(m_st[d], xv);
    if (m_dec[d] && m_cnt[d] < cfg_mode[d] * 0 + cfg_cmax[d]) m_cnt[d] = m_cnt[d] + 1;
    if (ri < 0) begin
      m_st[d] = 1; m_dec[d] = 1'b0;
      return;
    end
    if (rules[ri].lock >= 0) begin
      good = (rules[ri].lock >= cfg_kw[d]) || (kv[rules[ri].lock] == kval[rules[ri].lock]);
      ndec = !good;
    end else if (rules[ri].nx == m_st[d]) begin
      ndec = m_dec[d];
    end else begin
      ndec = 1'b0;
    end
    m_st[d]  = rules[ri].nx;
    m_dec[d] = ndec;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_st[d] = 1; m_dec[d] = 1'b0; m_cnt[d] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // One clock: drive at posedge, compare all instances, advance model at negedge.
  task automatic step(input logic [11:0] xv, input logic [3:0] kv);
    @(posedge clk);
    x = xv; k = kv;
    #1;
    for (int d = 0; d < 4; d++) begin
      ys[d] = y_dut[d];
      fs[d] = f_dut[d];
      chk($sformatf("y_dut%0d x=%h k=%b", d, xv, kv), y_dut[d], model_y(d, xv));
      chk($sformatf("fired_dut%0d", d), {9'b0, f_dut[d]}, {9'b0, m_cnt[d] >= cfg_th[d]});
    end
    @(negedge clk);
    for (int d = 0; d < 4; d++) model_adv(d, xv, kv);
  endtask

  task automatic do_reset();
    @(posedge clk);
    x = 12'hFFF; rst = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_y_dut%0d", d), y_dut[d], 10'h000);
      chk($sformatf("rst_fired_dut%0d", d), {9'b0, f_dut[d]}, 10'h000);
    end
    @(posedge clk);
    x = '0; rst = 1'b1;
  endtask

  initial begin
    add(1, X1|X11|X12, 0, Y4, 2, 1);
    add(1, X1|X11, X12, Y7|Y8, 3, -1);
    add(1, X1|X12|X8, X11, Y1|Y2, 4, -1);
    add(1, X1|X12|X5, X11|X8, Y2|Y3, 4, -1);
    add(1, X1|X12|X6, X11|X8|X5, Y10, 5, -1);
    add(1, X1|X12, X11|X8|X5|X6, Y4, 2, -1);
    add(1, X1|X10|X9, X11|X12, Y10, 5, -1);
    add(1, X1|X10, X11|X12|X9, Y1|Y2, 4, -1);
    add(1, X1|X9, X11|X12|X10, Y2|Y3, 4, -1);
    add(1, X1, X11|X12|X10|X9, Y4, 2, -1);
    add(1, 0, X1, 0, 1, -1);
    add(2, 0, 0, Y5, 1, -1);
    add(3, 0, 0, Y6, 6, 0);
    add(4, X4, 0, Y4, 2, 3);
    add(4, 0, X4, 0, 4, -1);
    add(5, X12, 0, Y2|Y9, 7, 2);
    add(5, 0, X12, Y2|Y3, 4, -1);
    add(6, X2|X3, 0, Y1|Y2, 4, -1);
    add(6, X2, X3, Y2|Y3, 4, -1);
    add(6, 0, X2, Y4, 2, -1);
    add(7, X7, 0, Y2|Y3, 4, -1);
    add(7, 0, X7, 0, 7, -1);

    // Reset state
    do_reset();

    // Correct key walk S1 -> S3 -> S6 -> S4 -> S2 -> S1
    step(X1|X11, 4'b1010); chk("walk_s1", ys[0], 10'h0C0);
    step(12'h000, 4'b1010); chk("walk_s3", ys[0], 10'h020);
    step(X2|X3, 4'b1010);   chk("walk_s6", ys[0], 10'h003);
    step(X4, 4'b1010);      chk("walk_s4", ys[0], 10'h008);
    step(12'h000, 4'b1010); chk("walk_s2", ys[0], 10'h010);
    chk("walk_fired", {6'b0, fs}, 10'h000);

    // key[0] wrong: five S6D visits, payload from visit 5
    for (int i = 1; i <= 5; i++) begin
      step(X1|X11, 4'b1011);
      step(12'h000, 4'b1011);
      step(X2|X3, 4'b1011);
      chk($sformatf("s6d_visit%0d", i), ys[0], (i < 5) ? 10'h003 : 10'h000);
      step(X4, 4'b1011);
      chk($sformatf("s6d_fired%0d", i), {9'b0, fs[0]}, {9'b0, i >= 5});
      step(12'h000, 4'b1011);
    end

    // key[2] wrong: S5 -> S7D, flip payload on dut1
    step(X1|X12|X6, 4'b1110);
    step(X12, 4'b1110);
    step(X7, 4'b1110);      chk("s7d_first", ys[1], 10'h3F9);
    step(X4, 4'b1110);
    step(12'h000, 4'b1110);
    step(X1|X12|X6, 4'b1110);
    step(X12, 4'b1110);
    step(12'h000, 4'b1110); chk("s7d_hold1", ys[1], 10'h3FF);
    step(12'h000, 4'b1110); chk("s7d_hold2", ys[1], 10'h3FF);
    step(X7, 4'b1110);      chk("s7d_exit", ys[1], 10'h3F9);

    // key[3] wrong: only KEY_W=2 instance stays genuine
    step(X4, 4'b0010);
    step(12'h000, 4'b0010);
    chk("kw2_s2", ys[2], 10'h010);
    chk("kw4_s2d", ys[0], 10'h000);

    // Narrow counter saturates without wrapping
    for (int i = 0; i < 3; i++) begin
      step(X1|X11, 4'b1011);
      step(12'h000, 4'b1011);
      step(X2|X3, 4'b1011);
      chk("sat_y", ys[3], 10'h000);
      chk("sat_fired", {9'b0, fs[3]}, 10'h001);
      step(X4, 4'b1011);
      step(12'h000, 4'b1011);
    end

    // Reset inside S6D with payload active
    step(X1|X11, 4'b1011);
    step(12'h000, 4'b1011);
    do_reset();
    step(X1|X11, 4'b1010);
    chk("post_rst_y", ys[0], 10'h0C0);
    chk("post_rst_fired", {6'b0, fs}, 10'h000);
    step(12'h000, 4'b1010);
    step(12'h000, 4'b1010);
    step(X4, 4'b1010);
    step(12'h000, 4'b1010);

    // Randomised run against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step(12'($urandom()), 4'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
